// File: rtl/fifo_sync_param.sv
// Synchronous single-clock FIFO with occupancy count, almost-full/empty thresholds,
// overflow/underflow pulses and selectable standard or first-word-fall-through read.
module fifo_sync_param #(
    parameter int unsigned DSIZE  = 8,
    parameter int unsigned ASIZE  = 4,
    parameter int unsigned AF_LVL = 12,
    parameter int unsigned AE_LVL = 4,
    parameter int unsigned FWFT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned DEPTH = 32'd1 << ASIZE;
    localparam int unsigned CW    = ASIZE + 1;

    logic [DSIZE-1:0] r_mem [DEPTH];
    logic [ASIZE:0]   r_wptr;
    logic [ASIZE:0]   r_rptr;
    logic [ASIZE:0]   r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_wr_en;
    logic             w_rd_en;
    logic [ASIZE-1:0] w_waddr;
    logic [ASIZE-1:0] w_raddr;

    // Flags depend on the registered count only, never on winc/rinc.
    assign wfull        = (r_count == CW'(DEPTH));
    assign rempty       = (r_count == '0);
    assign almost_full  = (r_count >= CW'(AF_LVL));
    assign almost_empty = (r_count <= CW'(AE_LVL));
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    assign w_wr_en = winc && !wfull;
    assign w_rd_en = rinc && !rempty;
    assign w_waddr = r_wptr[ASIZE-1:0];
    assign w_raddr = r_rptr[ASIZE-1:0];

    // Storage array; contents survive reset, only pointers are cleared.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + CW'(1);
            end
            if (w_rd_en) begin
                r_rptr <= r_rptr + CW'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_overflow  <= winc && wfull;
            r_underflow <= rinc && rempty;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; meaningless while empty.
            assign rdata = r_mem[w_raddr];
        end else begin : g_std
            logic [DSIZE-1:0] r_rdata;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rdata <= '0;
                end else if (w_rd_en) begin
                    r_rdata <= r_mem[w_raddr];
                end
            end

            assign rdata = r_rdata;
        end
    endgenerate

endmodule

// File: doc/fifo_sync_param.md
FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, named `clk` and `rst`.
REQ-002 Parameter DSIZE, default 8: data width in bits.
REQ-003 Parameter ASIZE, default 4: address width; DEPTH = 2^ASIZE entries.
REQ-004 Parameter AF_LVL, default 12: almost-full threshold; legal range 1..DEPTH.
REQ-005 Parameter AE_LVL, default 4: almost-empty threshold; legal range 0..DEPTH-1.
REQ-006 Parameter FWFT, default 0: 0 = standard read mode, 1 = first-word-fall-through mode.
REQ-007 clk  input  1  rising-edge clock for all state.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 wdata  input  DSIZE  write data.
REQ-010 winc  input  1  write request.
REQ-011 rinc  input  1  read request / pop.
REQ-012 rdata  output  DSIZE  read data.
REQ-013 wfull  output  1  FIFO holds DEPTH words.
REQ-014 rempty  output  1  FIFO holds 0 words.
REQ-015 almost_full  output  1  count >= AF_LVL.
REQ-016 almost_empty  output  1  count <= AE_LVL.
REQ-017 count  output  ASIZE+1  current occupancy, 0..DEPTH.
REQ-018 overflow  output  1  one-cycle pulse on a rejected write.
REQ-019 underflow  output  1  one-cycle pulse on a rejected read.

Function
REQ-020 Write accept: winc && !wfull; the word is stored at waddr on the clk edge, and the binary write pointer (ASIZE+1 bits) increments with natural wrap.
REQ-021 Read accept: rinc && !rempty; the binary read pointer (ASIZE+1 bits) increments with natural wrap.
REQ-022 Addresses SHALL be the pointer's low ASIZE bits; wrap from DEPTH-1 to 0 SHALL need no special case.
REQ-023 count SHALL be registered: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither.
REQ-024 wfull, rempty, almost_full and almost_empty SHALL decode from registered count only, with no combinational path from winc or rinc.
REQ-025 When full, winc SHALL be rejected even if rinc is accepted in the same cycle; the read proceeds and count becomes DEPTH-1.
REQ-026 When empty, rinc SHALL be rejected even if winc is accepted in the same cycle; the write proceeds and count becomes 1.
REQ-027 With simultaneous accepted read and write (0<count<DEPTH), both pointers SHALL advance and count SHALL hold.
REQ-028 overflow SHALL be registered and high for exactly the cycle after a rejected write (winc && wfull).
REQ-029 underflow SHALL be registered and high for exactly the cycle after a rejected read (rinc && rempty).
REQ-030 FWFT=0: rdata SHALL be a register loaded with mem[raddr] on an accepted read, valid on the cycle after the accepting edge, and held otherwise.
REQ-031 FWFT=1: rdata SHALL equal mem[raddr] whenever rempty=0, with the head word visible with no read request; rinc pops the word, and rdata SHALL be don't-care while rempty=1.
REQ-032 FWFT=1: a word written into an empty FIFO SHALL appear on rdata, with rempty low, on the cycle after the write edge.
REQ-033 Storage SHALL be a DEPTH x DSIZE register array written on clk.

Reset
REQ-034 While rst=1: both pointers 0, count 0, rempty 1, wfull 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, and the rdata register 0.
REQ-035 Reset assertion mid-operation SHALL discard all contents immediately (asynchronously); memory contents need not be cleared.
REQ-036 winc and rinc SHALL be ignored on the first clk edge after rst deasserts only if sampled while rst=1; from the next edge on, normal operation applies.

Verification
REQ-037 Fill: after reset, 16 writes of 0x00..0x0F -> count 16, wfull=1, almost_full asserted at count 12, almost_empty deasserted at count 5.
REQ-038 Overflow: full FIFO plus winc=1 with wdata=0xAA -> overflow pulse for 1 cycle, count stays 16, 0xAA never read out.
REQ-039 Drain and underflow, FWFT=0: 16 reads -> rdata 0x00..0x0F each one cycle after its read; then a rinc on the empty FIFO -> underflow pulse, rdata holds 0x0F.
REQ-040 Simultaneous: at count 8, winc=rinc=1 for 20 cycles -> count stays 8, data order preserved across pointer wrap.
REQ-041 Boundary: full plus winc&rinc -> count 15, write dropped; empty plus winc&rinc -> count 1, no underflow read data.
REQ-042 FWFT=1: write 0x5C into the empty FIFO -> next cycle rdata=0x5C, rempty=0; rst mid-fill at count 9 -> count 0, rempty=1 immediately.
